// File: rtl/par_to_ser_video_converter_if.sv
// AXI4-Stream bundle used by the stripe input and the raster output of the
// parallel-to-serial video converter.
interface axi4_stream_if #(
  parameter int unsigned DataWidth = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tstrb;
  logic [DataWidth/8-1:0] tkeep;
  logic                   tlast;
  logic                   tuser;
  logic [7:0]             tid;
  logic [3:0]             tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/par_to_ser_video_converter.sv
// Column-parallel stripe to raster video converter. Two ping-pong stripe banks
// let one stripe be written while the other drains line by line.
module par_to_ser_video_converter #(
  parameter int unsigned LINES_TO_OUTPUT = 8,
  parameter int unsigned PX_WIDTH        = 8,
  parameter int unsigned FRAME_RES_X     = 1280
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  parallel_video_i,
  axi4_stream_if.master video_o
);

  localparam int unsigned ColW      = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int unsigned LenW      = $clog2(FRAME_RES_X + 1);
  localparam int unsigned LineW     = (LINES_TO_OUTPUT > 1) ? $clog2(LINES_TO_OUTPUT) : 1;
  localparam int unsigned SkidDepth = 3;

  typedef logic [ColW-1:0]  col_t;
  typedef logic [LenW-1:0]  len_t;
  typedef logic [LineW-1:0] line_t;
  typedef logic [1:0]       ptr_t;

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  typedef struct packed {
    logic last;
    logic user;
    logic eos;
  } meta_t;

  typedef struct packed {
    logic [PX_WIDTH-1:0] data;
    meta_t               meta;
  } beat_t;

  // Bank state
  bank_st_e bank_st_q [2];
  bank_st_e bank_st_d [2];
  len_t     len_q     [2];
  len_t     len_d     [2];
  logic     sof_q     [2];
  logic     sof_d     [2];

  // Write side
  logic in_ready_q, in_ready_d;
  logic wr_bank_q, wr_bank_d;
  col_t wr_col_q, wr_col_d;
  logic sof_pend_q, sof_pend_d;
  logic wr_hs, wr_close;

  // Read side
  logic  rd_bank_q, rd_bank_d;
  line_t rd_line_q, rd_line_d;
  col_t  rd_col_q, rd_col_d;
  logic  rd_active_q, rd_active_d;
  logic  free_bank_q, free_bank_d;
  logic  rd_en, col_last, line_last, credit_ok, free_evt;

  // Registered RAM read stage and output skid buffer
  logic                s1_valid_q;
  meta_t               s1_meta_q, s1_meta_d;
  logic [PX_WIDTH-1:0] ram_rdata_q;
  beat_t               skid_q [SkidDepth];
  ptr_t                skid_wptr_q, skid_wptr_d;
  ptr_t                skid_rptr_q, skid_rptr_d;
  logic [1:0]          skid_cnt_q, skid_cnt_d;
  logic                skid_pop;
  beat_t               skid_head;

  logic [PX_WIDTH-1:0] mem_q [2][LINES_TO_OUTPUT][FRAME_RES_X];

  logic unused_in;
  assign unused_in = ^{parallel_video_i.tdata, parallel_video_i.tstrb, parallel_video_i.tkeep,
                       parallel_video_i.tid, parallel_video_i.tdest};

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(SkidDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  //////////////////
  // Write side   //
  //////////////////

  always_comb begin
    wr_hs      = parallel_video_i.tvalid && in_ready_q;
    wr_close   = wr_hs && (parallel_video_i.tlast || (wr_col_q == col_t'(FRAME_RES_X - 1)));
    wr_col_d   = wr_col_q;
    wr_bank_d  = wr_bank_q;
    sof_pend_d = sof_pend_q;
    len_d      = len_q;
    sof_d      = sof_q;
    if (wr_hs) begin
      if (wr_col_q == '0) sof_pend_d = parallel_video_i.tuser;
      wr_col_d = wr_col_q + 1'b1;
    end
    if (wr_close) begin
      len_d[wr_bank_q] = len_t'(wr_col_q) + 1'b1;
      sof_d[wr_bank_q] = (wr_col_q == '0) ? parallel_video_i.tuser : sof_pend_q;
      wr_col_d         = '0;
      wr_bank_d        = ~wr_bank_q;
    end
  end

  assign parallel_video_i.tready = in_ready_q;

  //////////////////
  // Read side    //
  //////////////////

  always_comb begin
    credit_ok   = ({1'b0, skid_cnt_q} + {2'b00, s1_valid_q}) < 3'(SkidDepth);
    rd_en       = ((bank_st_q[rd_bank_q] == StFull) || rd_active_q) && credit_ok;
    col_last    = (len_t'(rd_col_q) + 1'b1) == len_q[rd_bank_q];
    line_last   = rd_line_q == line_t'(LINES_TO_OUTPUT - 1);
    rd_bank_d   = rd_bank_q;
    rd_line_d   = rd_line_q;
    rd_col_d    = rd_col_q;
    rd_active_d = rd_active_q;
    s1_meta_d   = s1_meta_q;
    if (rd_en) begin
      s1_meta_d.last = col_last;
      s1_meta_d.user = sof_q[rd_bank_q] && (rd_line_q == '0) && (rd_col_q == '0);
      s1_meta_d.eos  = col_last && line_last;
      rd_active_d    = !(col_last && line_last);
      if (col_last) begin
        rd_col_d = '0;
        if (line_last) begin
          rd_line_d = '0;
          rd_bank_d = ~rd_bank_q;
        end else begin
          rd_line_d = rd_line_q + 1'b1;
        end
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  // A bank is released only once its final pixel leaves the output port.
  always_comb begin
    skid_head   = skid_q[skid_rptr_q];
    skid_pop    = (skid_cnt_q != '0) && video_o.tready;
    free_evt    = skid_pop && skid_head.meta.eos;
    free_bank_d = free_evt ? ~free_bank_q : free_bank_q;
    skid_wptr_d = s1_valid_q ? ptr_inc(skid_wptr_q) : skid_wptr_q;
    skid_rptr_d = skid_pop ? ptr_inc(skid_rptr_q) : skid_rptr_q;
    skid_cnt_d  = skid_cnt_q + {1'b0, s1_valid_q} - {1'b0, skid_pop};
  end

  //////////////////
  // Bank FSMs    //
  //////////////////

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_st_q[b];
      unique case (bank_st_q[b])
        StEmpty: begin
          if (wr_hs && (wr_bank_q == 1'(b))) bank_st_d[b] = wr_close ? StFull : StFilling;
        end
        StFilling: begin
          if (wr_close && (wr_bank_q == 1'(b))) bank_st_d[b] = StFull;
        end
        StFull: begin
          if (rd_en && (rd_bank_q == 1'(b))) bank_st_d[b] = StDraining;
        end
        StDraining: begin
          if (free_evt && (free_bank_q == 1'(b))) bank_st_d[b] = StEmpty;
        end
        default: bank_st_d[b] = StEmpty;
      endcase
    end
    in_ready_d = !(bank_st_d[wr_bank_d] inside {StFull, StDraining});
  end

  //////////////////
  // State        //
  //////////////////

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_st_q   <= '{default: StEmpty};
      len_q       <= '{default: '0};
      sof_q       <= '{default: 1'b0};
      in_ready_q  <= 1'b1;
      wr_bank_q   <= 1'b0;
      wr_col_q    <= '0;
      sof_pend_q  <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_line_q   <= '0;
      rd_col_q    <= '0;
      rd_active_q <= 1'b0;
      free_bank_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_meta_q   <= '0;
      skid_q      <= '{default: '0};
      skid_wptr_q <= '0;
      skid_rptr_q <= '0;
      skid_cnt_q  <= '0;
    end else begin
      bank_st_q   <= bank_st_d;
      len_q       <= len_d;
      sof_q       <= sof_d;
      in_ready_q  <= in_ready_d;
      wr_bank_q   <= wr_bank_d;
      wr_col_q    <= wr_col_d;
      sof_pend_q  <= sof_pend_d;
      rd_bank_q   <= rd_bank_d;
      rd_line_q   <= rd_line_d;
      rd_col_q    <= rd_col_d;
      rd_active_q <= rd_active_d;
      free_bank_q <= free_bank_d;
      s1_valid_q  <= rd_en;
      s1_meta_q   <= s1_meta_d;
      if (s1_valid_q) skid_q[skid_wptr_q] <= '{data: ram_rdata_q, meta: s1_meta_q};
      skid_wptr_q <= skid_wptr_d;
      skid_rptr_q <= skid_rptr_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  // Stripe storage: a whole column is written at once, one pixel read per cycle.
  always_ff @(posedge clk_i) begin
    if (wr_hs) begin
      for (int i = 0; i < LINES_TO_OUTPUT; i++) begin
        mem_q[wr_bank_q][i][wr_col_q] <= parallel_video_i.tdata[i*PX_WIDTH +: PX_WIDTH];
      end
    end
    if (rd_en) ram_rdata_q <= mem_q[rd_bank_q][rd_line_q][rd_col_q];
  end

  //////////////////
  // Outputs      //
  //////////////////

  always_comb begin
    video_o.tvalid                 = skid_cnt_q != '0;
    video_o.tdata                  = '0;
    video_o.tdata[PX_WIDTH-1:0]    = skid_head.data;
    video_o.tlast                  = skid_head.meta.last;
    video_o.tuser                  = skid_head.meta.user;
    video_o.tstrb                  = '1;
    video_o.tkeep                  = '1;
    video_o.tid                    = '0;
    video_o.tdest                  = '0;
  end

endmodule

// File: doc/par_to_ser_video_converter.md
# par_to_ser_video_converter

Inverse of the serial-to-parallel line converter on the decode/output side of the JPEG pipeline. The input is an AXI4-Stream carrying a stripe of LINES_TO_OUTPUT image lines in parallel: one beat holds one column, lane i is line i. The output is ordinary raster video, one pixel per beat, line by line, with tlast at end of line and tuser at start of frame. Two ping-pong stripe banks let the next stripe be written while the previous one drains.

## Interface
- LINES_TO_OUTPUT, 8: lines per stripe (input lanes).
- PX_WIDTH, 8: pixel width in bits.
- FRAME_RES_X, 1280: maximum pixels per line; sets the depth of each bank.
- Derived widths:
  - Output tdata = PX_WIDTH rounded up to a multiple of 8.
  - Input tdata = PX_WIDTH*LINES_TO_OUTPUT rounded up to a multiple of 8.
  - Lane i = bits [i*PX_WIDTH +: PX_WIDTH]. Padding bits are ignored on input and zero on output.
- clk_i  input  1  single clock for the whole block.
- rst_i  input  1  reset, synchronous, active-high.
- parallel_video_i  axi4_stream_if.slave  input tdata width  column-parallel stripe input. tlast marks the last column of the stripe; tuser marks the first column of a frame.
- video_o  axi4_stream_if.master  output tdata width  raster output.
  - tlast on the last pixel of each line.
  - tuser on pixel 0 of line 0 of a stripe whose first column had tuser set.
  - tstrb/tkeep are all ones; tid/tdest are 0.

## Operation
- Storage: two banks (0 and 1). Each bank holds LINES_TO_OUTPUT × FRAME_RES_X pixels, plus a full flag, a stored length len (1..FRAME_RES_X) and a stored sof flag.
- Write side
  - Pointer wr_bank and column counter wr_col.
  - parallel_video_i.tready = !full[wr_bank].
  - On each handshake, lane i is written to bank[wr_bank] line i, column wr_col.
  - A stripe closes on input tlast, or on wr_col == FRAME_RES_X-1, whichever comes first. On close:
    - len = wr_col+1.
    - sof = tuser of column 0.
    - full set.
    - wr_col cleared; wr_bank toggles.
  - Overlong input: beats after a forced close without tlast start the next stripe. No error is flagged.
- Read side
  - Pointer rd_bank; counters rd_line and rd_col.
  - Reading starts when full[rd_bank] is set. Order: line 0, columns 0..len-1, then line 1, and so on up to line LINES_TO_OUTPUT-1.
  - After the last pixel of the last line is handshaken on video_o: full[rd_bank] cleared, rd_bank toggles, counters cleared.
- States per bank: EMPTY -> (write handshake) FILLING -> (close) FULL -> (first read) DRAINING -> (last output handshake) EMPTY.
- Simultaneous events: if a bank closes and the other bank frees in the same cycle, both take effect; the freed bank is writable the next cycle.
- Throughput: input is accepted at 1 beat/cycle until both banks are full. Sustained rate is one stripe per LINES_TO_OUTPUT×len output cycles.

## Timing
- Reset values:
  - video_o.tvalid=0, tdata=0, tlast=0, tuser=0.
  - parallel_video_i.tready=1.
  - Both banks EMPTY; wr_bank=rd_bank=0; all counters 0.
- Reset mid-operation: all stored content is discarded and no partial line is emitted. The next input beat is treated as column 0 of bank 0.
- Memory is a registered-read RAM.
- Latency: video_o.tvalid for pixel 0 of a stripe rises exactly 2 cycles after the clock edge of the closing input handshake, provided the read side is idle.
- Output handshake:
  - tdata/tlast/tuser are held stable while tvalid=1 and tready=0.
  - With tready held high, the block emits 1 pixel per cycle with no bubbles across line and stripe boundaries, using an output skid stage of ≥2 entries.
- tready on video_o does not depend combinationally on video_o.tvalid. parallel_video_i.tready is a registered function of the bank flags.

## Test plan
- Basic stripe (LINES_TO_OUTPUT=8, PX_WIDTH=8, FRAME_RES_X=4; input columns 0..3, lane i = 16*i+col, tuser on col 0, tlast on col 3):
  - 32 output beats with values 0x00,0x01,0x02,0x03,0x10,…,0x73.
  - tlast on beats 3,7,…,31; tuser only on beat 0.
  - First tvalid 2 cycles after the closing handshake.
- Backpressure: same stimulus with video_o.tready random at 50%.
  - Identical output sequence.
  - Data held stable during stalls; no duplicated or dropped beats.
- Ping-pong with video_o.tready=0 and 3 stripes offered:
  - Stripes 1–2 accepted (8 beats); input tready=0 from then on.
  - After tready=1 and 32 output beats, input tready returns to 1 and stripe 3 is accepted.
- Short line: tlast on column 2 with FRAME_RES_X=4 -> 8 lines of 3 pixels each, tlast on beats 2,5,…,23.
- Overlong: 6 columns without tlast with FRAME_RES_X=4 -> bank closes after column 3; columns 4–5 land in the next bank as its columns 0–1.
- Reset mid-drain: assert rst_i for 1 cycle after 10 output beats.
  - Next cycle: video_o.tvalid=0 and input tready=1.
  - A fresh stripe then reproduces the basic-stripe output exactly.
